// File: rtl/conv_1st_out_unpack_if.sv
// -----------------------------------------------------------------------------
// conv_1st_out_unpack_if
//   Bundles the word-capture side and the byte-stream side of
//   conv_1st_out_unpack.
//
//   Word side     : conv_i (LANES*DW result word), valid_i (one-cycle strobe)
//   Byte stream   : pix_o, pix_valid_o, pix_ready_i, lane_o, sof_o, eol_o, eof_o
//   Status        : level_o (words held), overflow_o (sticky), drop_cnt_o
//
//   modport master : the unpacker itself (it masters the byte stream)
//   modport slave  : the surrounding environment (upstream conv + downstream sink)
// -----------------------------------------------------------------------------
interface conv_1st_out_unpack_if #(
    parameter int LANES = 40,
    parameter int DW    = 8
);
    logic [LANES*DW-1:0] conv_i;
    logic                valid_i;
    logic [DW-1:0]       pix_o;
    logic                pix_valid_o;
    logic                pix_ready_i;
    logic [5:0]          lane_o;
    logic                sof_o;
    logic                eol_o;
    logic                eof_o;
    logic [2:0]          level_o;
    logic                overflow_o;
    logic [7:0]          drop_cnt_o;

    modport master (
        input  conv_i, valid_i, pix_ready_i,
        output pix_o, pix_valid_o, lane_o, sof_o, eol_o, eof_o,
               level_o, overflow_o, drop_cnt_o
    );

    modport slave (
        output conv_i, valid_i, pix_ready_i,
        input  pix_o, pix_valid_o, lane_o, sof_o, eol_o, eof_o,
               level_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/conv_1st_out_unpack.sv
// -----------------------------------------------------------------------------
// conv_1st_out_unpack
//   Captures LANES x DW result words from conv_1st_top into a DEPTH-word FIFO
//   and replays each word one lane per ready/valid handshake, lane 0 (MSB
//   byte) first. Tracks the word position inside a FRAME_WORDS-word frame and
//   counts words dropped because the FIFO was full (upstream cannot stall).
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - conv_1st_out_unpack_if.master (word input, byte stream, status)
// -----------------------------------------------------------------------------
module conv_1st_out_unpack #(
    parameter int LANES       = 40,
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int FRAME_WORDS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    conv_1st_out_unpack_if.master    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [2:0]    DEPTH_L    = 3'(DEPTH);
    localparam logic [5:0]    LAST_LANE  = 6'(LANES - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAME_WORDS - 1);

    // EMPTY: no word held; STREAM: head word is being presented.
    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [LANES*DW-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [2:0]          level;
    logic [0:0]          state;
    logic [5:0]          lane_cnt;
    logic [FW-1:0]       frame_cnt;
    logic                overflow;
    logic [7:0]          drop_cnt;

    logic                pix_valid;
    logic                xfer, pop, wr_en, drop;
    logic [LANES*DW-1:0] head;
    logic [DW-1:0]       head_lane;

    assign pix_valid = (state == S_STREAM);
    assign xfer      = pix_valid & bus.pix_ready_i;
    assign pop       = xfer & (lane_cnt == LAST_LANE);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign wr_en     = bus.valid_i & ((level < DEPTH_L) | pop);
    assign drop      = bus.valid_i & ~wr_en;

    assign head = mem[rd_ptr];

    // Lane k sits at conv_i[(LANES-k)*DW-1 -: DW], so lane 0 is the MSB byte.
    always_comb begin
        // NOTE: default first so every path assigns head_lane -- no latch.
        head_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == 6'(k)) begin
                head_lane = head[(LANES-k)*DW-1 -: DW];
            end
        end
    end

    // NOTE: word storage carries no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.conv_i;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            state     <= S_EMPTY;
            lane_cnt  <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (xfer) begin
                if (pop) begin
                    lane_cnt  <= '0;
                    rd_ptr    <= rd_ptr + 1'b1;
                    frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
                end else begin
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end

            case ({wr_en, pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase

            case (state)
                S_EMPTY:  if (wr_en) state <= S_STREAM;
                S_STREAM: if (pop && !wr_en && level == 3'd1) state <= S_EMPTY;
                default:  state <= S_EMPTY;
            endcase

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Stream outputs are forced to zero while nothing is held.
    assign bus.pix_valid_o = pix_valid;
    assign bus.pix_o       = pix_valid ? head_lane : '0;
    assign bus.lane_o      = lane_cnt;
    assign bus.sof_o       = pix_valid & (lane_cnt == 6'd0) & (frame_cnt == '0);
    assign bus.eol_o       = pix_valid & (lane_cnt == LAST_LANE);
    assign bus.eof_o       = pix_valid & (lane_cnt == LAST_LANE) & (frame_cnt == LAST_FRAME);
    assign bus.level_o     = level;
    assign bus.overflow_o  = overflow;
    assign bus.drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_conv_1st_out_unpack.sv
// -----------------------------------------------------------------------------
// tb_conv_1st_out_unpack
//   Self-checking bench for conv_1st_out_unpack. A queue-based reference
//   model tracks accepted words, lane position, frame position and drops; a
//   negedge scoreboard compares every output against it each cycle, and the
//   scenario tasks add their own targeted checks.
// -----------------------------------------------------------------------------
module tb_conv_1st_out_unpack;
    localparam int LANES       = 40;
    localparam int DW          = 8;
    localparam int DEPTH       = 4;
    localparam int FRAME_WORDS = 32;
    localparam int WW          = LANES * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_1st_out_unpack_if #(.LANES(LANES), .DW(DW)) bus ();

    conv_1st_out_unpack #(
        .LANES(LANES), .DW(DW), .DEPTH(DEPTH), .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // Reference model state: accepted words in arrival order.
    logic [WW-1:0] m_q[$];
    int            m_lane  = 0;
    int            m_frame = 0;
    int            m_drops = 0;
    bit            m_ovf   = 1'b0;

    function automatic logic [DW-1:0] lane_of(input logic [WW-1:0] w, input int k);
        return w[(LANES-k)*DW-1 -: DW];
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < WW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    always @(posedge clk) begin : model
        bit fire;
        bit pop_now;
        fire = 1'b0;
        pop_now = 1'b0;
        if (rst) begin
            m_q.delete();
            m_lane  = 0;
            m_frame = 0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            fire    = (m_q.size() != 0) && bus.pix_ready_i;
            pop_now = fire && (m_lane == LANES-1);
            if (pop_now) begin
                void'(m_q.pop_front());
                m_lane  = 0;
                m_frame = (m_frame + 1) % FRAME_WORDS;
            end else if (fire) begin
                m_lane++;
            end
            if (bus.valid_i) begin
                if (m_q.size() < DEPTH) m_q.push_back(bus.conv_i);
                else begin
                    m_drops++;
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : scoreboard
        logic          e_valid;
        logic [DW-1:0] e_pix;
        logic          e_sof, e_eol, e_eof;
        logic [2:0]    e_level;
        logic [7:0]    e_drop;
        if (checking) begin
            e_valid = (m_q.size() != 0);
            if (e_valid) e_pix = lane_of(m_q[0], m_lane);
            else         e_pix = '0;
            e_sof   = e_valid && m_lane == 0 && m_frame == 0;
            e_eol   = e_valid && m_lane == LANES-1;
            e_eof   = e_eol && m_frame == FRAME_WORDS-1;
            e_level = 3'(m_q.size());
            e_drop  = (m_drops > 255) ? 8'd255 : 8'(m_drops);
            checks++;
            if ({bus.pix_valid_o, bus.pix_o, bus.lane_o, bus.sof_o, bus.eol_o, bus.eof_o,
                 bus.level_o, bus.overflow_o, bus.drop_cnt_o} !==
                {e_valid, e_pix, 6'(m_lane), e_sof, e_eol, e_eof, e_level, m_ovf, e_drop}) begin
                errors++;
                $display("FAIL scoreboard t=%0t got v=%b pix=%h lane=%0d sof/eol/eof=%b%b%b lvl=%0d ovf=%b drop=%0d expected v=%b pix=%h lane=%0d sof/eol/eof=%b%b%b lvl=%0d ovf=%b drop=%0d",
                         $time, bus.pix_valid_o, bus.pix_o, bus.lane_o, bus.sof_o, bus.eol_o,
                         bus.eof_o, bus.level_o, bus.overflow_o, bus.drop_cnt_o,
                         e_valid, e_pix, m_lane, e_sof, e_eol, e_eof, e_level, m_ovf, e_drop);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.pix_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        bus.conv_i  = w;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.pix_ready_i = 1'b0;
        bus.conv_i = '0;
        tick();
        tick();
        checking = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pix_valid_o !== 1'b0 || bus.level_o !== 3'd0 || bus.overflow_o !== 1'b0 ||
            bus.drop_cnt_o !== 8'd0 || bus.pix_o !== 8'd0 || bus.lane_o !== 6'd0 ||
            bus.sof_o !== 1'b0 || bus.eol_o !== 1'b0 || bus.eof_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b lvl=%0d ovf=%b drop=%0d pix=%h lane=%0d flags=%b%b%b required all zero",
                     bus.pix_valid_o, bus.level_o, bus.overflow_o, bus.drop_cnt_o, bus.pix_o,
                     bus.lane_o, bus.sof_o, bus.eol_o, bus.eof_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        logic [WW-1:0] w;
        for (int k = 0; k < LANES; k++) w[(LANES-k)*DW-1 -: DW] = 8'(k);
        bus.pix_ready_i = 1'b1;
        send_word(w);
        for (int k = 0; k < LANES; k++) begin
            @(negedge clk);
            checks++;
            if (bus.pix_valid_o !== 1'b1 || bus.pix_o !== 8'(k) || bus.lane_o !== 6'(k) ||
                bus.sof_o !== (k == 0) || bus.eol_o !== (k == LANES-1) || bus.eof_o !== 1'b0 ||
                bus.level_o !== 3'd1) begin
                errors++;
                $display("FAIL single_lane%0d got v=%b pix=%h lane=%0d sof=%b eol=%b eof=%b lvl=%0d required v=1 pix=%h lane=%0d sof=%b eol=%b eof=0 lvl=1",
                         k, bus.pix_valid_o, bus.pix_o, bus.lane_o, bus.sof_o, bus.eol_o,
                         bus.eof_o, bus.level_o, 8'(k), k, k == 0, k == LANES-1);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.pix_valid_o !== 1'b0 || bus.level_o !== 3'd0) begin
            errors++;
            $display("FAIL single_drained got v=%b lvl=%0d required v=0 lvl=0",
                     bus.pix_valid_o, bus.level_o);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [WW-1:0] w;
        bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit            hold = 1'b0;
        logic [DW-1:0] prev_pix = '0;
        logic [5:0]    prev_lane = '0;
        int            n = 0;
        int            c = 0;
        w = rand_word();
        bus.pix_ready_i = 1'b0;
        send_word(w);
        while (n < LANES && c < 400) begin
            bus.pix_ready_i = pat[c % 4];
            @(negedge clk);
            if (hold) begin
                checks++;
                if (bus.pix_o !== prev_pix || bus.lane_o !== prev_lane) begin
                    errors++;
                    $display("FAIL bp_hold got pix=%h lane=%0d required pix=%h lane=%0d",
                             bus.pix_o, bus.lane_o, prev_pix, prev_lane);
                end
            end
            if (bus.pix_valid_o === 1'b1) begin
                if (bus.pix_ready_i) begin
                    checks++;
                    if (bus.lane_o !== 6'(n) || bus.pix_o !== lane_of(w, n)) begin
                        errors++;
                        $display("FAIL bp_xfer%0d got pix=%h lane=%0d required pix=%h lane=%0d",
                                 n, bus.pix_o, bus.lane_o, lane_of(w, n), n);
                    end
                    n++;
                end
                hold = !bus.pix_ready_i;
                prev_pix = bus.pix_o;
                prev_lane = bus.lane_o;
            end else begin
                hold = 1'b0;
            end
            c++;
            tick();
        end
        bus.pix_ready_i = 1'b0;
        checks++;
        if (n !== LANES) begin
            errors++;
            $display("FAIL bp_count got transfers=%0d required %0d", n, LANES);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [WW-1:0] ws[6];
        int n = 0;
        do_reset();
        for (int i = 0; i < 6; i++) ws[i] = rand_word();
        for (int i = 0; i < 6; i++) send_word(ws[i]);
        @(negedge clk);
        checks++;
        if (bus.level_o !== 3'd4 || bus.overflow_o !== 1'b1 || bus.drop_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL ovf_status got lvl=%0d ovf=%b drop=%0d required lvl=4 ovf=1 drop=2",
                     bus.level_o, bus.overflow_o, bus.drop_cnt_o);
        end
        tick();
        bus.pix_ready_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.pix_valid_o === 1'b1) begin
                if (n < 4*LANES) begin
                    checks++;
                    if (bus.pix_o !== lane_of(ws[n/LANES], n%LANES) || bus.lane_o !== 6'(n%LANES)) begin
                        errors++;
                        $display("FAIL ovf_data%0d got pix=%h lane=%0d required pix=%h lane=%0d",
                                 n, bus.pix_o, bus.lane_o, lane_of(ws[n/LANES], n%LANES), n%LANES);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n !== 4*LANES) begin
            errors++;
            $display("FAIL ovf_count got transfers=%0d required %0d", n, 4*LANES);
        end
        tick();
    endtask

    task automatic test_full_pop();
        logic [WW-1:0] ws[5];
        bit found = 1'b0;
        int n = 0;
        do_reset();
        for (int i = 0; i < 5; i++) ws[i] = rand_word();
        for (int i = 0; i < 4; i++) send_word(ws[i]);
        bus.pix_ready_i = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.pix_valid_o === 1'b1 && bus.lane_o === 6'(LANES-1)) begin
                bus.conv_i  = ws[4];
                bus.valid_i = 1'b1;
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL fullpop_timeout got no lane %0d within budget required one", LANES-1);
        end
        tick();
        bus.valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level_o !== 3'd4 || bus.overflow_o !== 1'b0 || bus.drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL fullpop_status got lvl=%0d ovf=%b drop=%0d required lvl=4 ovf=0 drop=0",
                     bus.level_o, bus.overflow_o, bus.drop_cnt_o);
        end
        for (int c = 0; c < 200; c++) begin
            if (bus.pix_valid_o === 1'b1) begin
                if (n < 4*LANES) begin
                    checks++;
                    if (bus.pix_o !== lane_of(ws[1 + n/LANES], n%LANES)) begin
                        errors++;
                        $display("FAIL fullpop_data%0d got pix=%h required pix=%h",
                                 n, bus.pix_o, lane_of(ws[1 + n/LANES], n%LANES));
                    end
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n !== 4*LANES) begin
            errors++;
            $display("FAIL fullpop_count got transfers=%0d required %0d", n, 4*LANES);
        end
        tick();
    endtask

    task automatic test_frame_wrap();
        int word_idx = 0;
        int sof_n = 0;
        int eof_n = 0;
        do_reset();
        bus.pix_ready_i = 1'b1;
        for (int c = 0; c < 33*LANES + 50; c++) begin
            bus.valid_i = (c % LANES == 0) && (c < 33*LANES);
            if (bus.valid_i) bus.conv_i = rand_word();
            @(negedge clk);
            if (bus.pix_valid_o === 1'b1) begin
                if (bus.sof_o === 1'b1) begin
                    sof_n++;
                    checks++;
                    if (!(word_idx == 0 || word_idx == 32) || bus.lane_o !== 6'd0) begin
                        errors++;
                        $display("FAIL wrap_sof got word=%0d lane=%0d required word 0 or 32 lane 0",
                                 word_idx, bus.lane_o);
                    end
                end
                if (bus.eof_o === 1'b1) begin
                    eof_n++;
                    checks++;
                    if (word_idx != FRAME_WORDS-1 || bus.lane_o !== 6'(LANES-1)) begin
                        errors++;
                        $display("FAIL wrap_eof got word=%0d lane=%0d required word %0d lane %0d",
                                 word_idx, bus.lane_o, FRAME_WORDS-1, LANES-1);
                    end
                end
                if (bus.eol_o === 1'b1) word_idx++;
            end
            tick();
        end
        bus.valid_i = 1'b0;
        checks++;
        if (sof_n != 2 || eof_n != 1 || word_idx != 33 || bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_summary got sof=%0d eof=%0d words=%0d ovf=%b required sof=2 eof=1 words=33 ovf=0",
                     sof_n, eof_n, word_idx, bus.overflow_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w;
        bit found = 1'b0;
        do_reset();
        send_word(rand_word());
        send_word(rand_word());
        bus.pix_ready_i = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.pix_valid_o === 1'b1 && bus.lane_o === 6'd17) begin
                found = 1'b1;
                checks++;
                if (bus.level_o !== 3'd2) begin
                    errors++;
                    $display("FAIL midrst_pre got lvl=%0d required 2", bus.level_o);
                end
                rst = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_timeout got no lane 17 within budget required one");
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pix_valid_o !== 1'b0 || bus.level_o !== 3'd0 || bus.lane_o !== 6'd0) begin
            errors++;
            $display("FAIL midrst_after got v=%b lvl=%0d lane=%0d required v=0 lvl=0 lane=0",
                     bus.pix_valid_o, bus.level_o, bus.lane_o);
        end
        tick();
        w = rand_word();
        send_word(w);
        @(negedge clk);
        checks++;
        if (bus.pix_valid_o !== 1'b1 || bus.lane_o !== 6'd0 || bus.sof_o !== 1'b1 ||
            bus.pix_o !== lane_of(w, 0)) begin
            errors++;
            $display("FAIL midrst_restart got v=%b lane=%0d sof=%b pix=%h required v=1 lane=0 sof=1 pix=%h",
                     bus.pix_valid_o, bus.lane_o, bus.sof_o, bus.pix_o, lane_of(w, 0));
        end
        for (int c = 0; c < 50; c++) tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got time limit reached required run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.pix_ready_i = 1'b0;
        bus.conv_i = '0;
        test_reset();
        test_single_word();
        test_back_pressure();
        test_overflow();
        test_full_pop();
        test_frame_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
